bbs_seed_sched: RTL and testbench
=================================

BBS_SEED_SCHED -- requirements
Module: bbs_seed_sched

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the width of the seed, modulus and GCD operands.
REQ-002 The block SHALL have parameter MAX_TRY, default 8, giving the maximum number of GCD transactions per request (legal range 1..15).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 SHALL force reset state immediately.
REQ-005 req_val  input  1  seed-search request valid.
REQ-006 req_rdy  output  1  block ready to accept a request.
REQ-007 req_seed  input  W  candidate seed.
REQ-008 req_m  input  W  BBS modulus m.
REQ-009 gcd_a  output  W  GCD operand A, equal to latched m.
REQ-010 gcd_b  output  W  GCD operand B, equal to current seed.
REQ-011 gcd_val  output  1  GCD operands valid.
REQ-012 gcd_rdy  input  1  GCD unit ready for operands.
REQ-013 gcd_res  input  W  GCD result.
REQ-014 gcd_res_val  input  1  GCD result valid.
REQ-015 gcd_res_rdy  output  1  block ready to take the GCD result.
REQ-016 out_val  output  1  search result valid.
REQ-017 out_rdy  input  1  consumer ready for the result.
REQ-018 out_seed  output  W  final seed.
REQ-019 out_fail  output  1  1 = no coprime seed found, or illegal request.
REQ-020 out_tries  output  4  number of GCD transactions performed.

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-022 IDLE: req_rdy=1; on req_val, the block SHALL latch seed and m, clear tries, and go to ISSUE next cycle.
REQ-023 IDLE: if the accepted request has m<3, seed<2 or seed>=m, the block SHALL go to DONE with out_fail=1 and tries=0, and SHALL NOT assert gcd_val.
REQ-024 ISSUE: gcd_val=1 with gcd_a=m and gcd_b=seed held stable; on gcd_rdy, tries SHALL increment and the state SHALL go to WAIT.
REQ-025 WAIT: gcd_res_rdy=1; on gcd_res_val, if gcd_res==1 the block SHALL go to DONE with out_fail=0.
REQ-026 WAIT, on a non-unity result with tries==MAX_TRY, the block SHALL go to DONE with out_fail=1 and out_seed equal to the last tested seed.
REQ-027 WAIT, on a non-unity result with tries<MAX_TRY, the block SHALL set seed to seed+1 (W-bit) and go to ISSUE.
REQ-028 No wrap logic SHALL be implemented: seed never reaches m, because m-1 is always coprime to m.
REQ-029 DONE: out_val=1 with out_seed, out_fail and out_tries registered and stable; on out_rdy the state SHALL go to IDLE.
REQ-030 req_rdy SHALL be 0 in every state other than IDLE; requests arriving while busy are not accepted.
REQ-031 gcd_val SHALL be 1 only in ISSUE, and gcd_res_rdy SHALL be 1 only in WAIT.
REQ-032 Latency: with gcd_rdy=1 the block SHALL assert gcd_val the cycle after acceptance; out_val SHALL assert the cycle after the final gcd_res_val.
REQ-033 A gcd_res_val arriving outside WAIT SHALL be ignored.

Reset
REQ-034 While reset=0: state=IDLE, seed=0, m=0, tries=0.
REQ-035 While reset=0: req_rdy=0 and gcd_val=0, gcd_res_rdy=0, out_val=0, out_fail=0, out_seed=0, out_tries=0.
REQ-036 After reset deasserts, req_rdy SHALL be 1 at the first clock edge.
REQ-037 Reset asserted in any state SHALL abort the operation; no output is produced for the aborted request.

Verification
REQ-038 seed=3, m=253, GCD returns 1 -> exactly one GCD transaction; out_seed=3, out_fail=0, out_tries=1.
REQ-039 seed=3, m=6 -> GCD operands (6,3),(6,4),(6,5), results 3,2,1; out_seed=5, out_fail=0, out_tries=3.
REQ-040 MAX_TRY=2, seed=2, m=30 -> results 2,3; out_seed=3, out_fail=1, out_tries=2.
REQ-041 seed=0, m=253 -> out_val two cycles after acceptance; out_fail=1, out_tries=0; gcd_val never 1.
REQ-042 out_rdy=0 for 5 cycles in DONE -> out_* stable and req_rdy=0 throughout; out_rdy=1 -> IDLE next cycle.
REQ-043 Reset pulsed during WAIT -> all outputs immediately at reset values; a following request seed=3, m=253 completes as in REQ-038.

Source files
------------

// File: rtl/bbs_seed_sched.sv
// bbs_seed_sched: walks upward from a candidate seed until an external GCD
// unit reports it coprime to the BBS modulus, or the try budget runs out.
module bbs_seed_sched #(
    parameter int W       = 16,
    parameter int MAX_TRY = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_val,
    output logic         req_rdy,
    input  logic [W-1:0] req_seed,
    input  logic [W-1:0] req_m,
    output logic [W-1:0] gcd_a,
    output logic [W-1:0] gcd_b,
    output logic         gcd_val,
    input  logic         gcd_rdy,
    input  logic [W-1:0] gcd_res,
    input  logic         gcd_res_val,
    output logic         gcd_res_rdy,
    output logic         out_val,
    input  logic         out_rdy,
    output logic [W-1:0] out_seed,
    output logic         out_fail,
    output logic [3:0]   out_tries
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t       state;
    logic [W-1:0] seed;
    logic [W-1:0] m;
    logic [3:0]   tries;
    logic         bad;
    logic         req_bad;

    assign req_bad = (req_m < W'(3))
                  || (req_seed < W'(2))
                  || (req_seed >= req_m);

    assign gcd_a = m;
    assign gcd_b = seed;

    // Rejected requests still spend one cycle in ISSUE, with gcd_val held low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            seed        <= '0;
            m           <= '0;
            tries       <= '0;
            bad         <= 1'b0;
            req_rdy     <= 1'b0;
            gcd_val     <= 1'b0;
            gcd_res_rdy <= 1'b0;
            out_val     <= 1'b0;
            out_fail    <= 1'b0;
            out_seed    <= '0;
            out_tries   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_rdy <= 1'b1;
                    if (req_val && req_rdy) begin
                        seed    <= req_seed;
                        m       <= req_m;
                        tries   <= '0;
                        bad     <= req_bad;
                        req_rdy <= 1'b0;
                        gcd_val <= !req_bad;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bad) begin
                        out_val   <= 1'b1;
                        out_fail  <= 1'b1;
                        out_seed  <= seed;
                        out_tries <= tries;
                        state     <= DONE;
                    end else if (gcd_rdy) begin
                        tries       <= tries + 4'd1;
                        gcd_val     <= 1'b0;
                        gcd_res_rdy <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (gcd_res_val) begin
                        gcd_res_rdy <= 1'b0;
                        if (gcd_res == W'(1)) begin
                            out_val   <= 1'b1;
                            out_fail  <= 1'b0;
                            out_seed  <= seed;
                            out_tries <= tries;
                            state     <= DONE;
                        end else if (tries == 4'(MAX_TRY)) begin
                            out_val   <= 1'b1;
                            out_fail  <= 1'b1;
                            out_seed  <= seed;
                            out_tries <= tries;
                            state     <= DONE;
                        end else begin
                            // m-1 is always coprime to m, so no wrap is needed
                            seed    <= seed + W'(1);
                            gcd_val <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_val <= 1'b0;
                        req_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bbs_seed_sched.sv
// tb_bbs_seed_sched: vector table, directed reset sequences and random
// requests checked against a seed-search model using real GCD arithmetic.
module tb_bbs_seed_sched;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        req_val;
    logic [15:0] req_seed;
    logic [15:0] req_m;
    logic        gcd_rdy;
    logic [15:0] gcd_res;
    logic        gcd_res_val;
    logic        out_rdy;

    logic        rv0, rv1, gr0, gr1, gv0, gv1, or0, or1;
    logic        r0_req_rdy, r0_gcd_val, r0_gcd_res_rdy, r0_out_val, r0_out_fail;
    logic        r1_req_rdy, r1_gcd_val, r1_gcd_res_rdy, r1_out_val, r1_out_fail;
    logic [15:0] r0_gcd_a, r0_gcd_b, r0_out_seed;
    logic [15:0] r1_gcd_a, r1_gcd_b, r1_out_seed;
    logic [3:0]  r0_out_tries, r1_out_tries;

    logic        req_rdy, gcd_val, gcd_res_rdy, out_val, out_fail;
    logic [15:0] gcd_a, gcd_b, out_seed;
    logic [3:0]  out_tries;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_b[$];

    // Only the selected instance sees handshakes; the other idles.
    assign rv0 = req_val & ~sel;
    assign rv1 = req_val & sel;
    assign gr0 = gcd_rdy & ~sel;
    assign gr1 = gcd_rdy & sel;
    assign gv0 = gcd_res_val & ~sel;
    assign gv1 = gcd_res_val & sel;
    assign or0 = out_rdy & ~sel;
    assign or1 = out_rdy & sel;

    assign req_rdy     = sel ? r1_req_rdy : r0_req_rdy;
    assign gcd_val     = sel ? r1_gcd_val : r0_gcd_val;
    assign gcd_res_rdy = sel ? r1_gcd_res_rdy : r0_gcd_res_rdy;
    assign out_val     = sel ? r1_out_val : r0_out_val;
    assign out_fail    = sel ? r1_out_fail : r0_out_fail;
    assign gcd_a       = sel ? r1_gcd_a : r0_gcd_a;
    assign gcd_b       = sel ? r1_gcd_b : r0_gcd_b;
    assign out_seed    = sel ? r1_out_seed : r0_out_seed;
    assign out_tries   = sel ? r1_out_tries : r0_out_tries;

    bbs_seed_sched u0 (
        .clk(clk), .reset(reset),
        .req_val(rv0), .req_rdy(r0_req_rdy),
        .req_seed(req_seed), .req_m(req_m),
        .gcd_a(r0_gcd_a), .gcd_b(r0_gcd_b),
        .gcd_val(r0_gcd_val), .gcd_rdy(gr0),
        .gcd_res(gcd_res), .gcd_res_val(gv0),
        .gcd_res_rdy(r0_gcd_res_rdy),
        .out_val(r0_out_val), .out_rdy(or0),
        .out_seed(r0_out_seed), .out_fail(r0_out_fail),
        .out_tries(r0_out_tries)
    );

    bbs_seed_sched #(.MAX_TRY(2)) u1 (
        .clk(clk), .reset(reset),
        .req_val(rv1), .req_rdy(r1_req_rdy),
        .req_seed(req_seed), .req_m(req_m),
        .gcd_a(r1_gcd_a), .gcd_b(r1_gcd_b),
        .gcd_val(r1_gcd_val), .gcd_rdy(gr1),
        .gcd_res(gcd_res), .gcd_res_val(gv1),
        .gcd_res_rdy(r1_gcd_res_rdy),
        .out_val(r1_out_val), .out_rdy(or1),
        .out_seed(r1_out_seed), .out_fail(r1_out_fail),
        .out_tries(r1_out_tries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] gcd(input logic [15:0] a,
                                        input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Seeds tested in order, each against m, until coprime or out of tries.
    task automatic model(input logic [15:0] s, input logic [15:0] mm,
                         input int maxt, output logic [15:0] xs,
                         output bit xf, output int xt);
        logic [15:0] cur;
        exp_b.delete();
        xs = s;
        xf = 1'b1;
        xt = 0;
        if (mm < 16'd3 || s < 16'd2 || s >= mm) return;
        cur = s;
        for (int t = 1; t <= maxt; t++) begin
            exp_b.push_back(cur);
            xt = t;
            xs = cur;
            if (gcd(mm, cur) == 16'd1) begin
                xf = 1'b0;
                break;
            end
            cur = cur + 16'd1;
        end
    endtask

    task automatic run(input string nm, input logic [15:0] s,
                       input logic [15:0] mm, input int stall,
                       input bit use_exp, input logic [15:0] es,
                       input bit ef, input int et);
        logic [15:0] xs, cap_seed, cur_b;
        bit xf, done, vprev, rprev, resprev, resnext, busy_rdy, ok;
        int xt, n;
        logic [3:0] cap_tries;
        logic cap_fail;
        model(s, mm, sel ? 2 : 8, xs, xf, xt);
        if (use_exp) begin
            xs = es;
            xf = ef;
            xt = et;
        end
        check({nm, " idle rdy"}, 32'(req_rdy), 32'd1);
        req_val = 1'b1;
        req_seed = s;
        req_m = mm;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        done = 1'b0;
        busy_rdy = 1'b0;
        resprev = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc == 0)
                check({nm, " gcd_val lat"}, 32'(gcd_val), 32'(xt > 0));
            if (out_val) begin
                req_val = 1'b0;
                gcd_rdy = 1'b0;
                gcd_res_val = 1'b0;
                if (xt > 0)
                    check({nm, " out lat"}, 32'(resprev), 32'd1);
                else
                    check({nm, " out lat"}, cyc, 32'd1);
                check({nm, " seed"}, 32'(out_seed), 32'(xs));
                check({nm, " fail"}, 32'(out_fail), 32'(xf));
                check({nm, " tries"}, 32'(out_tries), 32'(xt));
                check({nm, " gcd txns"}, n, xt);
                cap_seed = out_seed;
                cap_fail = out_fail;
                cap_tries = out_tries;
                ok = 1'b1;
                for (int k = 0; k < stall; k++) begin
                    @(posedge clk);
                    #1;
                    if (!out_val || req_rdy || out_seed !== cap_seed ||
                        out_fail !== cap_fail || out_tries !== cap_tries)
                        ok = 1'b0;
                end
                check({nm, " hold"}, 32'(ok), 32'd1);
                out_rdy = 1'b1;
                @(posedge clk);
                #1;
                out_rdy = 1'b0;
                check({nm, " to idle"}, 32'({out_val, req_rdy}), 32'b01);
                done = 1'b1;
            end else begin
                if (req_rdy) busy_rdy = 1'b1;
                req_val = 1'($urandom_range(0, 1));
                req_seed = 16'($urandom);
                req_m = 16'($urandom);
                if (gcd_val) begin
                    if (n < exp_b.size()) begin
                        check({nm, " op a"}, 32'(gcd_a), 32'(mm));
                        check({nm, " op b"}, 32'(gcd_b), 32'(exp_b[n]));
                    end else begin
                        check({nm, " extra op"}, n, exp_b.size());
                    end
                end
                gcd_rdy = 1'($urandom_range(0, 1));
                vprev = gcd_val;
                rprev = gcd_rdy;
                gcd_res_val = 1'($urandom_range(0, 1));
                if (gcd_res_rdy) begin
                    cur_b = (n > 0 && n <= exp_b.size()) ? exp_b[n-1] : mm;
                    gcd_res = gcd(mm, cur_b);
                end else begin
                    gcd_res = 16'd1;
                end
                resnext = gcd_res_rdy && gcd_res_val;
                @(posedge clk);
                #1;
                if (vprev && rprev) n++;
                resprev = resnext;
            end
        end
        check({nm, " finished"}, 32'(done), 32'd1);
        check({nm, " busy rdy"}, 32'(busy_rdy), 32'd0);
        req_val = 1'b0;
        gcd_rdy = 1'b0;
        gcd_res_val = 1'b0;
    endtask

    typedef struct {
        bit          s1;
        logic [15:0] seed;
        logic [15:0] m;
        int          stall;
        logic [15:0] es;
        bit          ef;
        int          et;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1'b0, 16'd3,   16'd253,   5, 16'd3,   1'b0, 1};
        vt[1]  = '{1'b0, 16'd3,   16'd6,     0, 16'd5,   1'b0, 3};
        vt[2]  = '{1'b0, 16'd0,   16'd253,   1, 16'd0,   1'b1, 0};
        vt[3]  = '{1'b0, 16'd1,   16'd100,   0, 16'd1,   1'b1, 0};
        vt[4]  = '{1'b0, 16'd253, 16'd253,   0, 16'd253, 1'b1, 0};
        vt[5]  = '{1'b0, 16'd5,   16'd2,     0, 16'd5,   1'b1, 0};
        vt[6]  = '{1'b0, 16'd2,   16'd30030, 2, 16'd9,   1'b1, 8};
        vt[7]  = '{1'b0, 16'd99,  16'd100,   0, 16'd99,  1'b0, 1};
        vt[8]  = '{1'b1, 16'd2,   16'd30,    1, 16'd3,   1'b1, 2};
        vt[9]  = '{1'b1, 16'd3,   16'd6,     0, 16'd4,   1'b1, 2};
        vt[10] = '{1'b0, 16'd2,   16'd3,     3, 16'd2,   1'b0, 1};

        reset = 1'b0;
        sel = 1'b0;
        req_val = 1'b0;
        req_seed = '0;
        req_m = '0;
        gcd_rdy = 1'b0;
        gcd_res = '0;
        gcd_res_val = 1'b0;
        out_rdy = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset ctl", 32'({req_rdy, gcd_val, gcd_res_rdy, out_val,
                                out_fail, out_tries}), 32'd0);
        check("reset seed", 32'(out_seed), 32'd0);
        check("reset ops", {gcd_a, gcd_b}, 32'd0);
        reset = 1'b1;
        #1;
        check("rdy pre edge", 32'(req_rdy), 32'd0);
        @(posedge clk);
        #1;
        check("rdy first edge", 32'(req_rdy), 32'd1);

        for (int i = 0; i < 11; i++) begin
            sel = vt[i].s1;
            run($sformatf("vec%0d", i), vt[i].seed, vt[i].m, vt[i].stall,
                1'b1, vt[i].es, vt[i].ef, vt[i].et);
        end

        // Reset pulsed while waiting on a GCD result.
        sel = 1'b0;
        req_val = 1'b1;
        req_seed = 16'd3;
        req_m = 16'd253;
        gcd_rdy = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        @(posedge clk);
        #1;
        gcd_rdy = 1'b0;
        check("wait reached", 32'(gcd_res_rdy), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("abort ctl", 32'({req_rdy, gcd_val, gcd_res_rdy, out_val,
                                out_fail, out_tries}), 32'd0);
        check("abort seed", 32'(out_seed), 32'd0);
        check("abort ops", {gcd_a, gcd_b}, 32'd0);
        gcd_res = 16'd1;
        gcd_res_val = 1'b1;
        @(posedge clk);
        #1;
        gcd_res_val = 1'b0;
        check("abort held", 32'({req_rdy, out_val, gcd_res_rdy}), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort no out", 32'({out_val, req_rdy}), 32'b01);
        run("post abort", 16'd3, 16'd253, 0, 1'b1, 16'd3, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] rm, rs;
            int k;
            sel = ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 9);
            if (k == 0) begin
                rm = 16'd30030;
                rs = 16'($urandom_range(2, 40));
            end else begin
                rm = 16'($urandom_range(3, 400));
                rs = 16'($urandom_range(2, int'(rm) - 1));
            end
            if (k == 1) rs = 16'($urandom_range(0, 1));
            if (k == 2) rs = rm + 16'($urandom_range(0, 5));
            run($sformatf("rnd%0d", i), rs, rm, $urandom_range(0, 3),
                1'b0, 16'd0, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
